// File: rtl/pipelined_adder_sub.sv
// Pipelined K-bit adder/subtractor: one W-bit slice per stage, with the slice carry registered
// between stages. The whole pipeline advances or stalls together under a valid/ready handshake.
module pipelined_adder_sub #(
  parameter int K      = 16,
  parameter int STAGES = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  input  logic         CarryIn,
  input  logic         Sub,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [K-1:0] O,
  output logic         CarryOutAdder,
  output logic         Overflow,
  output logic         Zero
);
  localparam int W = K / STAGES;
  localparam int L = STAGES - 1;

  // Index s of each *_q array holds what stage s registered.
  logic [STAGES-1:0] v_q;
  logic [K-1:0]      a_q   [STAGES];
  logic [K-1:0]      b_q   [STAGES];
  logic [K-1:0]      sum_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic              ovf_q;
  logic              zero_q;

  logic [K-1:0]      sum_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic              zero_d;

  // Operands, carry, partial sum and valid entering each stage.
  logic [K-1:0]      src_a   [STAGES];
  logic [K-1:0]      src_b   [STAGES];
  logic [K-1:0]      src_sum [STAGES];
  logic              src_c   [STAGES];
  logic              src_v   [STAGES];
  logic [W:0]        slice_sum;
  logic              adv;

  assign adv      = !v_q[L] || OutReady;
  assign InReady  = adv;
  assign OutValid = v_q[L];
  assign O        = sum_q[L];
  assign CarryOutAdder = c_q[L];
  assign Overflow = ovf_q;
  assign Zero     = zero_q;

  always_comb begin
    src_a[0]   = A;
    src_b[0]   = Sub ? ~B : B;
    src_c[0]   = Sub | CarryIn;
    src_sum[0] = '0;
    src_v[0]   = InValid;
    for (int s = 1; s < STAGES; s++) begin
      src_a[s]   = a_q[s-1];
      src_b[s]   = b_q[s-1];
      src_sum[s] = sum_q[s-1];
      src_c[s]   = c_q[s-1];
      src_v[s]   = v_q[s-1];
    end
  end

  always_comb begin
    slice_sum = '0;
    c_d       = '0;
    for (int s = 0; s < STAGES; s++) begin
      slice_sum = {1'b0, src_a[s][s*W +: W]} + {1'b0, src_b[s][s*W +: W]} + (W+1)'(src_c[s]);
      sum_d[s]  = src_sum[s];
      sum_d[s][s*W +: W] = slice_sum[W-1:0];
      c_d[s]    = slice_sum[W];
    end
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    ovf_d  = src_a[L][K-1] ^ src_b[L][K-1] ^ sum_d[L][K-1] ^ c_d[L];
    zero_d = (sum_d[L] == '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= src_v[s];
        // Data only moves with a valid operation so bubbles leave O/flags untouched.
        if (src_v[s]) begin
          a_q[s]   <= src_a[s];
          b_q[s]   <= src_b[s];
          sum_q[s] <= sum_d[s];
          c_q[s]   <= c_d[s];
        end
      end
      if (src_v[L]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: K=16/STAGES=4, K=8/STAGES=2 and K=8/STAGES=1 instances,
// checked against an arithmetic reference model and a table of known results.
module tb_pipelined_adder_sub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        x16_iv, x16_ir, x16_ci, x16_sub, x16_ov, x16_or, x16_c, x16_v, x16_z;
  logic [15:0] x16_a, x16_b, x16_o;
  logic        x8_iv, x8_ir, x8_ci, x8_sub, x8_ov, x8_or, x8_c, x8_v, x8_z;
  logic [7:0]  x8_a, x8_b, x8_o;
  logic        x1_iv, x1_ir, x1_ci, x1_sub, x1_ov, x1_or, x1_c, x1_v, x1_z;
  logic [7:0]  x1_a, x1_b, x1_o;

  pipelined_adder_sub #(.K(16), .STAGES(4)) u16 (
    .Clk(clk), .Reset(rst), .InValid(x16_iv), .InReady(x16_ir), .A(x16_a), .B(x16_b),
    .CarryIn(x16_ci), .Sub(x16_sub), .OutValid(x16_ov), .OutReady(x16_or), .O(x16_o),
    .CarryOutAdder(x16_c), .Overflow(x16_v), .Zero(x16_z));

  pipelined_adder_sub #(.K(8), .STAGES(2)) u8 (
    .Clk(clk), .Reset(rst), .InValid(x8_iv), .InReady(x8_ir), .A(x8_a), .B(x8_b),
    .CarryIn(x8_ci), .Sub(x8_sub), .OutValid(x8_ov), .OutReady(x8_or), .O(x8_o),
    .CarryOutAdder(x8_c), .Overflow(x8_v), .Zero(x8_z));

  pipelined_adder_sub #(.K(8), .STAGES(1)) u1 (
    .Clk(clk), .Reset(rst), .InValid(x1_iv), .InReady(x1_ir), .A(x1_a), .B(x1_b),
    .CarryIn(x1_ci), .Sub(x1_sub), .OutValid(x1_ov), .OutReady(x1_or), .O(x1_o),
    .CarryOutAdder(x1_c), .Overflow(x1_v), .Zero(x1_z));

  typedef struct packed {
    logic [15:0] o;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] o;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  res_t exp_q[$];
  res_t mon_e;

  // Reference: plain unsigned/signed arithmetic, no slicing.
  function automatic res_t model(int k, longint a, longint b, bit ci, bit sub);
    res_t   r;
    longint m, sa, sb, u, s, um;
    m  = longint'(1) << k;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      u   = a - b;
      s   = sa - sb;
      r.c = (a >= b);
    end else begin
      u   = a + b + longint'(ci);
      s   = sa + sb + longint'(ci);
      r.c = (u >= m);
    end
    um  = ((u % m) + m) % m;
    r.o = 16'(um);
    r.v = (s < -(m / 2)) || (s >= m / 2);
    r.z = (um == 0);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 16-bit instance: push on transfer in, compare on transfer out.
  always @(posedge clk) begin
    if (x16_ov && x16_or) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stale16 got=%0h want=no_output", x16_o);
      end else begin
        mon_e = exp_q.pop_front();
        n_out++;
        chk("out16", {x16_o, x16_c, x16_v, x16_z}, {mon_e.o, mon_e.c, mon_e.v, mon_e.z});
      end
    end
    if (rst) exp_q.delete();
    else if (x16_iv && x16_ir) exp_q.push_back(model(16, x16_a, x16_b, x16_ci, x16_sub));
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    int          lat;
    int          n0;
    logic [18:0] save;
    logic [7:0]  pat;
    res_t        e;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

    x16_a = '0; x16_b = '0; x16_ci = 0; x16_sub = 0; x16_or = 1;
    x8_a = '0; x8_b = '0; x8_ci = 0; x8_sub = 0; x8_iv = 0; x8_or = 1;
    x1_a = '0; x1_b = '0; x1_ci = 0; x1_sub = 0; x1_iv = 0; x1_or = 1;
    // Operand offered during reset must not be accepted.
    rst = 1; x16_iv = 1; x16_a = 16'h0005;
    step(); step();
    chk("rst_ov16", x16_ov, 0);
    chk("rst_o16", x16_o, 0);
    chk("rst_ir16", x16_ir, 1);
    chk("rst_flags16", {x16_c, x16_v, x16_z}, 0);
    chk("rst_ov8", x8_ov, 0);
    chk("rst_o8", x8_o, 0);
    chk("rst_ir8", x8_ir, 1);
    rst = 0; x16_iv = 0;
    repeat (5) step();
    chk("no_capture_in_rst", n_out, 0);

    // Table vectors on K=8, STAGES=2
    for (int i = 0; i < 10; i++) begin
      x8_a = tbl[i].a; x8_b = tbl[i].b; x8_ci = tbl[i].ci; x8_sub = tbl[i].sub; x8_iv = 1;
      step();
      x8_iv = 0;
      lat = 0;
      while (!x8_ov && lat < 10) begin step(); lat++; end
      chk("lat8", lat, 1);
      chk("vec8", {x8_o, x8_c, x8_v, x8_z}, {tbl[i].o, tbl[i].c, tbl[i].v, tbl[i].z});
      step();
    end

    // Carry through three stage boundaries
    x16_a = 16'h0FFF; x16_b = 16'h0001; x16_ci = 0; x16_sub = 0; x16_iv = 1;
    step();
    x16_iv = 0;
    lat = 0;
    while (!x16_ov && lat < 10) begin step(); lat++; end
    chk("lat16", lat, 3);
    chk("xcarry16", x16_o, 16'h1000);
    step();

    // Back-to-back random stream: 20 results in 20 consecutive cycles
    n0 = n_out;
    for (int i = 0; i < 20; i++) begin
      x16_a = 16'($urandom); x16_b = 16'($urandom);
      x16_ci = 1'($urandom); x16_sub = 1'($urandom); x16_iv = 1;
      step();
    end
    x16_iv = 0;
    repeat (4) step();
    chk("thru16", n_out - n0, 20);

    // Backpressure with op1 at the output
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      x16_a = 16'(16'h1111 * (i + 1)); x16_b = 16'h0101; x16_ci = 0; x16_sub = 0; x16_iv = 1;
      step();
    end
    x16_iv = 0;
    step();
    chk("bp_op1_ov", x16_ov, 1);
    x16_or = 0;
    x16_a = 16'hDEAD; x16_b = 16'hBEEF; x16_iv = 1;
    save = {x16_o, x16_c, x16_v, x16_z};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {x16_o, x16_c, x16_v, x16_z}, save);
      chk("bp_ir", x16_ir, 0);
      chk("bp_ov", x16_ov, 1);
    end
    x16_iv = 0; x16_or = 1;
    repeat (6) step();
    chk("bp_count", n_out - n0, 3);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      x16_a = 16'($urandom); x16_b = 16'($urandom);
      x16_ci = 1'($urandom); x16_sub = 1'($urandom);
      x16_iv = 1'($urandom);
      x16_or = ($urandom_range(0, 3) != 0);
      step();
    end
    x16_iv = 0; x16_or = 1;
    repeat (8) step();
    chk("drain16", exp_q.size(), 0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      x16_a = 16'(16'h0100 + i); x16_b = 16'h0002; x16_sub = 0; x16_ci = 0; x16_iv = 1;
      step();
    end
    rst = 1;
    step();
    rst = 0; x16_iv = 0;
    chk("mid_rst_ov", x16_ov, 0);
    chk("mid_rst_o", x16_o, 0);
    chk("mid_rst_ir", x16_ir, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_ov", x16_ov, 0);
    end
    x16_a = 16'h0010; x16_b = 16'h0020; x16_iv = 1;
    step();
    x16_iv = 0;
    lat = 0;
    while (!x16_ov && lat < 10) begin step(); lat++; end
    chk("fresh_lat", lat, 3);
    chk("fresh_o", x16_o, 16'h0030);
    step();

    // STAGES=1 instance
    x1_a = 8'h12; x1_b = 8'h34; x1_ci = 1; x1_sub = 0; x1_iv = 1;
    step();
    x1_iv = 0;
    chk("s1_ov", x1_ov, 1);
    chk("s1_o", x1_o, 8'h47);
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      x1_a = 8'($urandom); x1_b = 8'($urandom); x1_ci = 1'($urandom); x1_sub = 1'($urandom);
      x1_iv = pat[i];
      e = model(8, x1_a, x1_b, x1_ci, x1_sub);
      step();
      chk("s1_gap_ov", x1_ov, pat[i]);
      if (pat[i]) chk("s1_gap_res", {x1_o, x1_c, x1_v, x1_z}, {e.o[7:0], e.c, e.v, e.z});
    end
    x1_iv = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
